// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        DONE
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return (tick_hz > 0) ? clk_hz / tick_hz : 0;
    endfunction

endpackage

// File: rtl/stopwatch_counter_bcd_decade.sv
// One BCD digit of the elapsed-time chain; carry_out ripples combinationally into the next decade.
module bcd_decade
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [3:0] value,
    output logic       carry_out
);

    // NOTE: flops take non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            value <= '0;
        end else if (en) begin
            value <= (value == BCD_MAX) ? '0 : value + 4'd1;
        end
    end

    assign carry_out = en && (value == BCD_MAX);

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch core: centisecond prescaler, run/pause FSM and four BCD decades (SS.hh).
// Define STOPWATCH_WRAP_EN to wrap 99.99 -> 00.00 with a one-cycle overflow pulse instead of stopping.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic       running,
    output logic       overflow
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    if (TICK_HZ <= 0 || DIV < 2 || DIV * TICK_HZ != CLK_HZ) begin : g_bad_div
        $error("stopwatch_counter: CLK_HZ/TICK_HZ must be an integer of at least 2");
    end

    state_t        state;
    logic [PW-1:0] prescaler;
    logic          tick;
    logic          limit;
    logic [4:0]    carry;
    bcd_t          digits [4];

    assign tick = (state == RUN) && (prescaler == PRE_MAX);

`ifdef STOPWATCH_WRAP_EN
    assign carry[0] = tick;
    assign limit    = carry[4];
`else
    logic all_nines;

    assign all_nines = (digits[0] == BCD_MAX) && (digits[1] == BCD_MAX) &&
                       (digits[2] == BCD_MAX) && (digits[3] == BCD_MAX);
    // The chain is gated at 99.99 so the count freezes there instead of wrapping.
    assign carry[0]  = tick && !all_nines;
    assign limit     = tick && all_nines;

    always_comb begin
        assert (!carry[4]);
    end
`endif

    for (genvar i = 0; i < 4; i++) begin : g_decade
        bcd_decade u_decade (
            .clk       (clk),
            .reset     (reset),
            .clr       (clear),
            .en        (carry[i]),
            .value     (digits[i]),
            .carry_out (carry[i+1])
        );
    end

    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state     <= IDLE;
            running   <= 1'b0;
            overflow  <= 1'b0;
            prescaler <= '0;
        end else begin
`ifdef STOPWATCH_WRAP_EN
            overflow <= limit;
`endif
            case (state)
                IDLE: begin
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    prescaler <= tick ? '0 : prescaler + 1'b1;
                    if (start_stop) begin
                        state   <= PAUSE;
                        running <= 1'b0;
                    end
`ifndef STOPWATCH_WRAP_EN
                    else if (limit) begin
                        state    <= DONE;
                        running  <= 1'b0;
                        overflow <= 1'b1;
                    end
`endif
                end
                PAUSE: begin
                    // Prescaler is retained so the resumed interval continues where it stopped.
                    if (start_stop) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                DONE: begin
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule
